// File: rtl/kick_pkg.sv
// Shared definitions for the kick arbiter: state encoding, command modes, strength width.
package kick_pkg;

    localparam int STRENGTH_W = 8;
    localparam int POWER_W    = 7;
    localparam int TICKS_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_FIRE     = 2'd2,
        ST_COOLDOWN = 2'd3
    } kick_state_t;

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_FLAT = 2'b01;
    localparam logic [1:0] MODE_CHIP = 2'b10;

    // Reserved mode and zero power both behave as a cancel.
    function automatic logic is_kick(input logic [1:0] mode, input logic [POWER_W-1:0] power);
        return ((mode == MODE_FLAT) || (mode == MODE_CHIP)) && (power != '0);
    endfunction

endpackage

// File: rtl/ir_debounce.sv
// Two-flop synchronizer plus debounce filter for the asynchronous ball-in-mouth IR sensor.
module ir_debounce #(
    parameter int IR_DEBOUNCE = 16
) (
    input  logic clk0,
    input  logic rst_n,
    input  logic ir_raw,
    output logic ir_db
);

    localparam int CW = (IR_DEBOUNCE > 1) ? $clog2(IR_DEBOUNCE + 1) : 1;

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;

    // ir_db flips only after IR_DEBOUNCE consecutive synced samples disagree with it.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
            ir_db  <= 1'b0;
        end else begin
            sync_1 <= ir_raw;
            sync_2 <= sync_1;
            if (sync_2 == ir_db) begin
                cnt <= '0;
            end else if (cnt == CW'(IR_DEBOUNCE - 1)) begin
                ir_db <= sync_2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/kick_arbiter.sv
// Kick command initiator: latches an MCU kick request, waits for ball and charge, fires the
// shooter with a stable strength and an en pulse, then holds off through the shooter lockout.
module kick_arbiter
    import kick_pkg::*;
#(
    parameter int TICK_DIV          = 2502,
    parameter int ARM_TIMEOUT_TICKS = 4000,
    parameter int COOLDOWN_TICKS    = 10001,
    parameter int IR_DEBOUNCE       = 16,
    parameter int EN_PULSE_CYCLES   = 4
) (
    input  logic                  clk0,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_mode,
    input  logic [POWER_W-1:0]    cmd_power,
    input  logic                  cmd_force,
    input  logic                  ir_ball,
    input  logic                  cap_ready,
    output logic [STRENGTH_W-1:0] strength,
    output logic                  en,
    output logic                  busy,
    output logic                  kick_done,
    output logic                  timeout,
    output logic                  ir_db,
    output logic [1:0]            state_o
);

    localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FIRE_W = $clog2(EN_PULSE_CYCLES + 1);

    // Handshake: a command transfers on a rising clk0 edge where cmd_valid and cmd_ready are
    // both high; cmd_ready is high only in IDLE/ARMED and low while reset is asserted.
    kick_state_t          state;
    logic                 rst_done;
    logic [DIV_W-1:0]     div_cnt;
    logic [TICKS_W-1:0]   tick_cnt;
    logic [FIRE_W-1:0]    fire_cnt;
    logic                 lat_chip;
    logic [POWER_W-1:0]   lat_power;
    logic                 lat_force;

    logic                 tick;
    logic [TICKS_W:0]     tick_cnt_p1;
    logic                 accept;
    logic                 new_kick;
    logic                 cancel;
    logic                 fire_ok;
    logic                 arm_expired;
    logic                 cool_expired;

    ir_debounce #(
        .IR_DEBOUNCE(IR_DEBOUNCE)
    ) u_ir_debounce (
        .clk0  (clk0),
        .rst_n (rst_n),
        .ir_raw(ir_ball),
        .ir_db (ir_db)
    );

    assign cmd_ready = rst_done && ((state == ST_IDLE) || (state == ST_ARMED));
    assign busy      = (state != ST_IDLE);
    assign state_o   = state;

    assign tick         = (div_cnt == DIV_W'(TICK_DIV - 1));
    assign tick_cnt_p1  = {1'b0, tick_cnt} + 1'b1;
    assign accept       = cmd_valid && cmd_ready;
    assign new_kick     = accept && is_kick(cmd_mode, cmd_power);
    assign cancel       = accept && !is_kick(cmd_mode, cmd_power);
    assign fire_ok      = cap_ready && (ir_db || lat_force);
    // Limits compare against the count the current tick produces, so expiry lands exactly
    // LIMIT*TICK_DIV cycles after state entry.
    assign arm_expired  = (ARM_TIMEOUT_TICKS != 0) && tick &&
                          (tick_cnt_p1 >= (TICKS_W+1)'(ARM_TIMEOUT_TICKS));
    assign cool_expired = tick && (tick_cnt_p1 >= (TICKS_W+1)'(COOLDOWN_TICKS));

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rst_done  <= 1'b0;
            div_cnt   <= '0;
            tick_cnt  <= '0;
            fire_cnt  <= '0;
            lat_chip  <= 1'b0;
            lat_power <= '0;
            lat_force <= 1'b0;
            strength  <= '0;
            en        <= 1'b0;
            kick_done <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            rst_done  <= 1'b1;
            kick_done <= 1'b0;
            timeout   <= 1'b0;

            if (tick) begin
                div_cnt <= '0;
                if (!tick_cnt_p1[TICKS_W]) tick_cnt <= tick_cnt_p1[TICKS_W-1:0];
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            // Any timer clear below overrides the free-running update above.
            case (state)
                ST_IDLE: begin
                    if (new_kick) begin
                        lat_chip  <= (cmd_mode == MODE_CHIP);
                        lat_power <= cmd_power;
                        lat_force <= cmd_force;
                        state     <= ST_ARMED;
                        div_cnt   <= '0;
                        tick_cnt  <= '0;
                    end
                end
                ST_ARMED: begin
                    if (new_kick) begin
                        lat_chip  <= (cmd_mode == MODE_CHIP);
                        lat_power <= cmd_power;
                        lat_force <= cmd_force;
                        div_cnt   <= '0;
                        tick_cnt  <= '0;
                    end else if (cancel) begin
                        state    <= ST_IDLE;
                        div_cnt  <= '0;
                        tick_cnt <= '0;
                    end else if (fire_ok) begin
                        strength <= {lat_chip, lat_power};
                        fire_cnt <= '0;
                        state    <= ST_FIRE;
                        div_cnt  <= '0;
                        tick_cnt <= '0;
                    end else if (arm_expired) begin
                        timeout  <= 1'b1;
                        state    <= ST_IDLE;
                        div_cnt  <= '0;
                        tick_cnt <= '0;
                    end
                end
                ST_FIRE: begin
                    // First FIRE cycle is strength setup with en low.
                    if (fire_cnt == FIRE_W'(EN_PULSE_CYCLES)) begin
                        en       <= 1'b0;
                        state    <= ST_COOLDOWN;
                        div_cnt  <= '0;
                        tick_cnt <= '0;
                    end else begin
                        en       <= 1'b1;
                        fire_cnt <= fire_cnt + 1'b1;
                    end
                end
                ST_COOLDOWN: begin
                    if (cool_expired) begin
                        strength  <= '0;
                        kick_done <= 1'b1;
                        state     <= ST_IDLE;
                        div_cnt   <= '0;
                        tick_cnt  <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kick_arbiter.sv
// Self-checking bench for kick_arbiter with shortened timing parameters.
module tb_kick_arbiter;

    localparam int T_DIV      = 4;
    localparam int ARM_TO     = 20;
    localparam int CD         = 10;
    localparam int DEB        = 3;
    localparam int EN_P       = 4;
    localparam int MAXW       = 128;
    localparam int TIMEOUT_AT = ARM_TO * T_DIV;
    localparam int DONE_AFTER = 1 + EN_P + CD * T_DIV;

    logic       clk0 = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [6:0] cmd_power;
    logic       cmd_force;
    logic       ir_ball;
    logic       cap_ready;
    logic [7:0] strength;
    logic       en;
    logic       busy;
    logic       kick_done;
    logic       timeout;
    logic       ir_db;
    logic [1:0] state_o;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    logic       en_prev = 1'b0;

    logic       en_s[MAXW];
    logic [7:0] str_s[MAXW];
    logic [1:0] st_s[MAXW];
    logic       done_s[MAXW];
    logic       to_s[MAXW];
    logic       db_s[MAXW];

    int         m_en_cnt, m_en_first, m_done_at, m_done_cnt, m_to_at, m_to_cnt;
    bit         m_str_stable;

    kick_arbiter #(
        .TICK_DIV(T_DIV), .ARM_TIMEOUT_TICKS(ARM_TO), .COOLDOWN_TICKS(CD),
        .IR_DEBOUNCE(DEB), .EN_PULSE_CYCLES(EN_P)
    ) dut (
        .clk0(clk0), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_power(cmd_power), .cmd_force(cmd_force),
        .ir_ball(ir_ball), .cap_ready(cap_ready), .strength(strength), .en(en),
        .busy(busy), .kick_done(kick_done), .timeout(timeout), .ir_db(ir_db),
        .state_o(state_o)
    );

    always #5 clk0 = ~clk0;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: every rising en must present the oldest expected strength.
    always @(negedge clk0) begin
        if (rst_n && en && !en_prev) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_strength: got unexpected fire strength=%02h expected no fire", strength);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (strength !== e) begin
                    miscompares++;
                    $display("FAIL sb_strength: got %02h expected %02h", strength, e);
                end
            end
        end
        en_prev <= en;
    end

    task automatic issue_cmd(input logic [1:0] mode, input logic [6:0] power,
                             input logic frc, output logic ready_seen);
        @(negedge clk0);
        cmd_valid = 1'b1;
        cmd_mode  = mode;
        cmd_power = power;
        cmd_force = frc;
        #1 ready_seen = cmd_ready;
        @(posedge clk0);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic set_ball(input logic v);
        ir_ball = v;
        repeat (DEB + 4) @(negedge clk0);
    endtask

    // Sample k is taken at the falling edge after the k-th rising edge following issue.
    task automatic record(input int n, input int cap_at);
        for (int k = 0; k < n; k++) begin
            @(negedge clk0);
            en_s[k]   = en;
            str_s[k]  = strength;
            st_s[k]   = state_o;
            done_s[k] = kick_done;
            to_s[k]   = timeout;
            db_s[k]   = ir_db;
            if (k + 1 == cap_at) cap_ready = 1'b1;
        end
    endtask

    task automatic measure(input int n);
        logic [7:0] first_str;
        m_en_cnt = 0; m_en_first = -1; m_done_at = -1; m_done_cnt = 0;
        m_to_at = -1; m_to_cnt = 0; m_str_stable = 1'b1; first_str = '0;
        for (int k = 0; k < n; k++) begin
            if (en_s[k]) begin
                if (m_en_first < 0) begin
                    m_en_first = k;
                    first_str  = str_s[k];
                end else if (str_s[k] !== first_str) begin
                    m_str_stable = 1'b0;
                end
                m_en_cnt++;
            end
            if (done_s[k]) begin
                if (m_done_at < 0) m_done_at = k;
                m_done_cnt++;
            end
            if (to_s[k]) begin
                if (m_to_at < 0) m_to_at = k;
                m_to_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        logic [15:0] got;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = 2'b00; cmd_power = '0;
        cmd_force = 1'b0; ir_ball = 1'b0; cap_ready = 1'b0;
        repeat (3) @(negedge clk0);
        got = {cmd_ready, en, strength, busy, kick_done, timeout, ir_db, state_o};
        vectors++;
        if (got !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %04h expected 0000", got);
        end
        rst_n = 1'b1;
        @(negedge clk0);
        vectors++;
        if (cmd_ready !== 1'b1 || state_o !== 2'd0) begin
            miscompares++;
            $display("FAIL ready_after_reset: got ready=%0b state=%0d expected ready=1 state=0", cmd_ready, state_o);
        end
    endtask

    task automatic test_flat_fire();
        logic rdy;
        cap_ready = 1'b1;
        set_ball(1'b1);
        vectors++;
        if (ir_db !== 1'b1) begin miscompares++; $display("FAIL flat_ir_db: got %0b expected 1", ir_db); end
        exp_q.push_back(8'h32);
        issue_cmd(2'b01, 7'd50, 1'b0, rdy);
        vectors++;
        if (rdy !== 1'b1) begin miscompares++; $display("FAIL flat_ready: got %0b expected 1", rdy); end
        record(60, -1);
        measure(60);
        vectors++;
        if (st_s[0] !== 2'd1) begin miscompares++; $display("FAIL flat_armed: got %0d expected 1", st_s[0]); end
        vectors++;
        if (st_s[1] !== 2'd2 || en_s[1] !== 1'b0 || str_s[1] !== 8'h32) begin
            miscompares++;
            $display("FAIL flat_setup: got st=%0d en=%0b str=%02h expected st=2 en=0 str=32", st_s[1], en_s[1], str_s[1]);
        end
        vectors++;
        if (m_en_first !== 2 || m_en_cnt !== EN_P) begin
            miscompares++;
            $display("FAIL flat_en_pulse: got first=%0d cnt=%0d expected first=2 cnt=%0d", m_en_first, m_en_cnt, EN_P);
        end
        vectors++;
        if (!m_str_stable || st_s[6] !== 2'd3 || str_s[6] !== 8'h32) begin
            miscompares++;
            $display("FAIL flat_cooldown_hold: got st=%0d str=%02h stable=%0b expected st=3 str=32 stable=1", st_s[6], str_s[6], m_str_stable);
        end
        vectors++;
        if (m_done_at !== 1 + DONE_AFTER || m_done_cnt !== 1) begin
            miscompares++;
            $display("FAIL flat_done: got at=%0d cnt=%0d expected at=%0d cnt=1", m_done_at, m_done_cnt, 1 + DONE_AFTER);
        end
        vectors++;
        if (str_s[1 + DONE_AFTER] !== 8'h00 || st_s[1 + DONE_AFTER] !== 2'd0 || m_to_cnt !== 0) begin
            miscompares++;
            $display("FAIL flat_end: got str=%02h st=%0d to=%0d expected str=00 st=0 to=0", str_s[1 + DONE_AFTER], st_s[1 + DONE_AFTER], m_to_cnt);
        end
    endtask

    task automatic test_chip_force();
        logic rdy;
        set_ball(1'b0);
        vectors++;
        if (ir_db !== 1'b0) begin miscompares++; $display("FAIL chip_ir_db: got %0b expected 0", ir_db); end
        exp_q.push_back(8'h8A);
        issue_cmd(2'b10, 7'd10, 1'b1, rdy);
        record(60, -1);
        measure(60);
        vectors++;
        if (m_en_first !== 2 || m_en_cnt !== EN_P) begin
            miscompares++;
            $display("FAIL chip_en_pulse: got first=%0d cnt=%0d expected first=2 cnt=%0d", m_en_first, m_en_cnt, EN_P);
        end
        vectors++;
        if (m_done_at !== 1 + DONE_AFTER) begin
            miscompares++;
            $display("FAIL chip_done: got %0d expected %0d", m_done_at, 1 + DONE_AFTER);
        end
    endtask

    task automatic test_timeout();
        logic rdy;
        issue_cmd(2'b01, 7'd20, 1'b0, rdy);
        record(90, -1);
        measure(90);
        vectors++;
        if (m_to_at !== TIMEOUT_AT || m_to_cnt !== 1) begin
            miscompares++;
            $display("FAIL timeout_pulse: got at=%0d cnt=%0d expected at=%0d cnt=1", m_to_at, m_to_cnt, TIMEOUT_AT);
        end
        vectors++;
        if (m_en_cnt !== 0 || st_s[TIMEOUT_AT-1] !== 2'd1 || st_s[TIMEOUT_AT] !== 2'd0) begin
            miscompares++;
            $display("FAIL timeout_state: got en=%0d st_before=%0d st_at=%0d expected en=0 1 0", m_en_cnt, st_s[TIMEOUT_AT-1], st_s[TIMEOUT_AT]);
        end
    endtask

    task automatic test_cancel();
        logic rdy;
        issue_cmd(2'b01, 7'd30, 1'b0, rdy);
        record(5, -1);
        vectors++;
        if (st_s[4] !== 2'd1) begin miscompares++; $display("FAIL cancel_armed: got %0d expected 1", st_s[4]); end
        issue_cmd(2'b00, 7'd0, 1'b0, rdy);
        record(20, -1);
        measure(20);
        vectors++;
        if (rdy !== 1'b1 || st_s[0] !== 2'd0 || busy !== 1'b0 || m_en_cnt !== 0 || m_to_cnt !== 0) begin
            miscompares++;
            $display("FAIL cancel_idle: got rdy=%0b st=%0d busy=%0b en=%0d to=%0d expected 1 0 0 0 0", rdy, st_s[0], busy, m_en_cnt, m_to_cnt);
        end
        issue_cmd(2'b01, 7'd0, 1'b0, rdy);
        record(5, -1);
        vectors++;
        if (st_s[0] !== 2'd0 || st_s[4] !== 2'd0) begin
            miscompares++;
            $display("FAIL power0_ignored: got st=%0d,%0d expected 0,0", st_s[0], st_s[4]);
        end
        issue_cmd(2'b11, 7'd77, 1'b1, rdy);
        record(5, -1);
        vectors++;
        if (st_s[0] !== 2'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reserved_ignored: got st=%0d busy=%0b expected 0 0", st_s[0], busy);
        end
    endtask

    task automatic test_glitch();
        logic rdy;
        issue_cmd(2'b01, 7'd40, 1'b0, rdy);
        record(3, -1);
        @(negedge clk0) ir_ball = 1'b1;
        @(negedge clk0);
        @(negedge clk0) ir_ball = 1'b0;
        record(10, -1);
        measure(10);
        vectors++;
        if (m_en_cnt !== 0 || db_s[0] !== 1'b0 || db_s[5] !== 1'b0 || db_s[9] !== 1'b0 || st_s[9] !== 2'd1) begin
            miscompares++;
            $display("FAIL glitch_rejected: got en=%0d db=%0b%0b%0b st=%0d expected en=0 db=000 st=1", m_en_cnt, db_s[0], db_s[5], db_s[9], st_s[9]);
        end
        exp_q.push_back(8'h28);
        ir_ball = 1'b1;
        record(60, -1);
        measure(60);
        vectors++;
        if (db_s[3] !== 1'b0 || db_s[4] !== 1'b1) begin
            miscompares++;
            $display("FAIL glitch_db_latency: got db3=%0b db4=%0b expected 0 1", db_s[3], db_s[4]);
        end
        vectors++;
        if (st_s[5] !== 2'd2 || m_en_first !== 6 || m_en_cnt !== EN_P || m_done_at !== 5 + DONE_AFTER) begin
            miscompares++;
            $display("FAIL held_fires: got st=%0d first=%0d cnt=%0d done=%0d expected 2 6 %0d %0d", st_s[5], m_en_first, m_en_cnt, m_done_at, EN_P, 5 + DONE_AFTER);
        end
    endtask

    task automatic test_reset_mid_fire();
        logic rdy;
        exp_q.push_back(8'h3C);
        issue_cmd(2'b01, 7'd60, 1'b0, rdy);
        record(3, -1);
        vectors++;
        if (en_s[2] !== 1'b1) begin miscompares++; $display("FAIL midfire_en_high: got %0b expected 1", en_s[2]); end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (en !== 1'b0 || strength !== 8'h00 || cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midfire_async: got en=%0b str=%02h rdy=%0b expected 0 00 0", en, strength, cmd_ready);
        end
        @(negedge clk0) rst_n = 1'b1;
        @(negedge clk0);
        vectors++;
        if (state_o !== 2'd0 || cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midfire_release: got st=%0d rdy=%0b expected 0 1", state_o, cmd_ready);
        end
    endtask

    task automatic test_cooldown_blocks();
        logic rdy;
        set_ball(1'b1);
        exp_q.push_back(8'h19);
        issue_cmd(2'b01, 7'd25, 1'b0, rdy);
        record(10, -1);
        vectors++;
        if (st_s[9] !== 2'd3) begin miscompares++; $display("FAIL cd_state: got %0d expected 3", st_s[9]); end
        @(negedge clk0);
        cmd_valid = 1'b1; cmd_mode = 2'b10; cmd_power = 7'd100; cmd_force = 1'b1;
        #1;
        vectors++;
        if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL cd_ready: got %0b expected 0", cmd_ready); end
        repeat (3) @(negedge clk0);
        cmd_valid = 1'b0;
        record(50, -1);
        measure(50);
        vectors++;
        if (m_done_cnt !== 1 || m_en_cnt !== 0 || st_s[49] !== 2'd0 || str_s[49] !== 8'h00) begin
            miscompares++;
            $display("FAIL cd_cmd_dropped: got done=%0d en=%0d st=%0d str=%02h expected 1 0 0 00", m_done_cnt, m_en_cnt, st_s[49], str_s[49]);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic       rdy, ball, frc, chip, fires;
            logic [6:0] pwr;
            int         cap_at, f;
            ball   = 1'($urandom_range(0, 1));
            frc    = 1'($urandom_range(0, 1));
            chip   = 1'($urandom_range(0, 1));
            pwr    = 7'($urandom_range(1, 127));
            cap_at = $urandom_range(0, 8);
            fires  = ball | frc;
            f      = (cap_at > 1) ? cap_at : 1;
            cap_ready = (cap_at == 0);
            set_ball(ball);
            if (fires) exp_q.push_back({chip, pwr});
            issue_cmd(chip ? 2'b10 : 2'b01, pwr, frc, rdy);
            record(90, cap_at);
            measure(90);
            vectors++;
            if (fires && (m_en_first !== f + 1 || m_en_cnt !== EN_P || m_done_at !== f + DONE_AFTER || m_to_cnt !== 0)) begin
                miscompares++;
                $display("FAIL rand_fire[%0d]: got first=%0d cnt=%0d done=%0d to=%0d expected %0d %0d %0d 0", it, m_en_first, m_en_cnt, m_done_at, m_to_cnt, f + 1, EN_P, f + DONE_AFTER);
            end else if (!fires && (m_en_cnt !== 0 || m_to_at !== TIMEOUT_AT || m_done_cnt !== 0)) begin
                miscompares++;
                $display("FAIL rand_timeout[%0d]: got en=%0d to=%0d done=%0d expected 0 %0d 0", it, m_en_cnt, m_to_at, m_done_cnt, TIMEOUT_AT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_flat_fire();
        test_chip_force();
        test_timeout();
        test_cancel();
        test_glitch();
        test_reset_mid_fire();
        test_cooldown_blocks();
        test_random();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
